screen_writer: RTL and testbench

SCREEN_WRITER -- requirements
Module: screen_writer

---
 rtl/screen_writer.sv | 202 ++++++++++++++++++++
 tb/tb_screen_writer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/screen_writer.sv
// Text-mode screen writer: turns a received byte stream into character-buffer
// writes over a circular ROWS x COLS buffer, with cursor control and scrolling.
module screen_writer #(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [COL_BITS-1:0]  cursor_x,
  output logic [ROW_BITS-1:0]  cursor_y,
  output logic [ADDR_BITS-1:0] first_char,
  output logic                 buf_we,
  output logic [ADDR_BITS-1:0] buf_addr,
  output logic [7:0]           buf_wdata
);

  localparam int N = ROWS * COLS;
  localparam logic [ADDR_BITS:0]   N_W      = (ADDR_BITS+1)'(N);
  localparam logic [ADDR_BITS:0]   COLS_W   = (ADDR_BITS+1)'(COLS);
  localparam logic [ADDR_BITS-1:0] COLS_A   = ADDR_BITS'(COLS);
  localparam logic [COL_BITS-1:0]  LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [7:0]           SPACE    = 8'h20;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

  // Circular address sum; both operands are already below N.
  function automatic logic [ADDR_BITS-1:0] add_mod(
    input logic [ADDR_BITS-1:0] a,
    input logic [ADDR_BITS-1:0] b
  );
    logic [ADDR_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= N_W) begin
      sum = sum - N_W;
    end else begin
      sum = sum;
    end
    return sum[ADDR_BITS-1:0];
  endfunction

  state_t               state_r, state_s;
  logic [ADDR_BITS:0]   cnt_r, cnt_s;
  logic [COL_BITS-1:0]  cursor_x_r, cursor_x_s;
  logic [ROW_BITS-1:0]  cursor_y_r, cursor_y_s;
  logic [ADDR_BITS-1:0] first_char_r, first_char_s;
  logic [ADDR_BITS-1:0] line_addr_r, line_addr_s;
  logic                 in_ready_r, in_ready_s;
  logic                 buf_we_r, buf_we_s;
  logic [ADDR_BITS-1:0] buf_addr_r, buf_addr_s;
  logic [7:0]           buf_wdata_r, buf_wdata_s;
  logic [COL_BITS:0]    tab_s;
  logic [ADDR_BITS-1:0] line_next_s;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= CLEAR_ALL;
      cnt_r        <= '0;
      cursor_x_r   <= '0;
      cursor_y_r   <= '0;
      first_char_r <= '0;
      line_addr_r  <= '0;
      in_ready_r   <= 1'b0;
      buf_we_r     <= 1'b0;
      buf_addr_r   <= '0;
      buf_wdata_r  <= SPACE;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      cursor_x_r   <= cursor_x_s;
      cursor_y_r   <= cursor_y_s;
      first_char_r <= first_char_s;
      line_addr_r  <= line_addr_s;
      in_ready_r   <= in_ready_s;
      buf_we_r     <= buf_we_s;
      buf_addr_r   <= buf_addr_s;
      buf_wdata_r  <= buf_wdata_s;
    end
  end

  // Next-state, cursor and write-port logic.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    cursor_x_s   = cursor_x_r;
    cursor_y_s   = cursor_y_r;
    first_char_s = first_char_r;
    line_addr_s  = line_addr_r;
    in_ready_s   = 1'b0;
    buf_we_s     = 1'b0;
    buf_addr_s   = buf_addr_r;
    buf_wdata_s  = buf_wdata_r;
    tab_s        = {1'b0, cursor_x_r[COL_BITS-1:3], 3'b000} + (COL_BITS+1)'(8);
    line_next_s  = add_mod(line_addr_r, COLS_A);

    case (state_r)
      CLEAR_ALL: begin
        if (cnt_r < N_W) begin
          buf_we_s    = 1'b1;
          buf_addr_s  = cnt_r[ADDR_BITS-1:0];
          buf_wdata_s = SPACE;
          cnt_s       = cnt_r + (ADDR_BITS+1)'(1);
        end else begin
          state_s    = IDLE;
          in_ready_s = 1'b1;
        end
      end

      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid && in_ready_r) begin
          case (in_data)
            8'h0D: cursor_x_s = '0;
            8'h08: begin
              if (cursor_x_r != '0) begin
                cursor_x_s = cursor_x_r - COL_BITS'(1);
              end else begin
                cursor_x_s = cursor_x_r;
              end
            end
            8'h09: begin
              if (tab_s > {1'b0, LAST_COL}) begin
                cursor_x_s = LAST_COL;
              end else begin
                cursor_x_s = tab_s[COL_BITS-1:0];
              end
            end
            8'h0A: begin
              if (cursor_y_r < LAST_ROW) begin
                cursor_y_s  = cursor_y_r + ROW_BITS'(1);
                line_addr_s = line_next_s;
              end else begin
                // Scroll: the first clear write goes out with the LF itself.
                first_char_s = add_mod(first_char_r, COLS_A);
                line_addr_s  = line_next_s;
                buf_we_s     = 1'b1;
                buf_addr_s   = line_next_s;
                buf_wdata_s  = SPACE;
                cnt_s        = (ADDR_BITS+1)'(1);
                state_s      = CLEAR_ROW;
                in_ready_s   = 1'b0;
              end
            end
            default: begin
              if ((in_data >= 8'h20) && (in_data <= 8'h7E)) begin
                buf_we_s    = 1'b1;
                buf_addr_s  = add_mod(line_addr_r, ADDR_BITS'(cursor_x_r));
                buf_wdata_s = in_data;
                if (cursor_x_r == LAST_COL) begin
                  cursor_x_s = cursor_x_r;
                end else begin
                  cursor_x_s = cursor_x_r + COL_BITS'(1);
                end
              end else begin
                buf_we_s = 1'b0;
              end
            end
          endcase
        end else begin
          buf_we_s = 1'b0;
        end
      end

      CLEAR_ROW: begin
        if (cnt_r < COLS_W) begin
          buf_we_s    = 1'b1;
          buf_addr_s  = add_mod(line_addr_r, cnt_r[ADDR_BITS-1:0]);
          buf_wdata_s = SPACE;
          cnt_s       = cnt_r + (ADDR_BITS+1)'(1);
        end else begin
          state_s    = IDLE;
          in_ready_s = 1'b1;
        end
      end

      default: begin
        state_s = CLEAR_ALL;
        cnt_s   = '0;
      end
    endcase
  end

  assign in_ready   = in_ready_r;
  assign cursor_x   = cursor_x_r;
  assign cursor_y   = cursor_y_r;
  assign first_char = first_char_r;
  assign buf_we     = buf_we_r;
  assign buf_addr   = buf_addr_r;
  assign buf_wdata  = buf_wdata_r;

endmodule

// File: tb/tb_screen_writer.sv
// Directed self-checking bench for screen_writer (default 24x80 geometry).
module tb_screen_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [10:0] first_char;
  logic        buf_we;
  logic [10:0] buf_addr;
  logic [7:0]  buf_wdata;

  int compared = 0;
  int mismatched = 0;

  screen_writer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .first_char(first_char), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // {in_ready, buf_we, buf_addr, buf_wdata}
  function automatic logic [31:0] port(input logic rdy, input logic we,
                                       input int addr, input logic [7:0] d);
    return {11'd0, rdy, we, addr[10:0], d};
  endfunction

  task automatic clear_all_check(input string tag);
    for (int i = 0; i < 1920; i++) begin
      tick();
      check(tag, {11'd0, in_ready, buf_we, buf_addr, buf_wdata}, port(1'b0, 1'b1, i, 8'h20));
    end
    tick();
    check({tag, "_done"}, {11'd0, in_ready, buf_we, 19'd0}, {11'd0, 1'b1, 1'b0, 19'd0});
    check({tag, "_home"}, {cursor_x, cursor_y, first_char}, 32'd0);
  endtask

  int writes;

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) tick();
    check("rst_port", {11'd0, in_ready, buf_we, buf_addr, buf_wdata}, port(1'b0, 1'b0, 0, 8'h20));
    check("rst_home", {cursor_x, cursor_y, first_char}, 32'd0);

    reset = 1'b0;
    clear_all_check("clear_all");

    // Tab stops, saturation at the last column, BS, CR, ignored bytes.
    for (int k = 1; k <= 10; k++) begin
      send(8'h09);
      check("tab", {buf_we, cursor_x}, {1'b0, (k < 10) ? 7'(8 * k) : 7'd79});
    end
    send(8'h5A);
    check("z1", {buf_we, buf_addr, buf_wdata, cursor_x}, {1'b1, 11'd79, 8'h5A, 7'd79});
    send(8'h5A);
    check("z2", {buf_we, buf_addr, buf_wdata, cursor_x}, {1'b1, 11'd79, 8'h5A, 7'd79});
    send(8'h08);
    check("bs", {buf_we, cursor_x}, {1'b0, 7'd78});
    send(8'h09);
    check("tab_cap", {buf_we, cursor_x}, {1'b0, 7'd79});
    send(8'h1B);
    check("esc", {buf_we, cursor_x, cursor_y}, {1'b0, 7'd79, 5'd0});
    send(8'h7F);
    check("del", {buf_we, cursor_x}, {1'b0, 7'd79});
    send(8'h0D);
    check("cr", {buf_we, cursor_x}, {1'b0, 7'd0});
    send(8'h08);
    check("bs_zero", {buf_we, cursor_x}, {1'b0, 7'd0});
    send(8'h09);
    check("tab0", {buf_we, cursor_x}, {1'b0, 7'd8});
    send(8'h0D);

    // "AB" CR LF "C" back-to-back.
    send(8'h41);
    check("a", {buf_we, buf_addr, buf_wdata, cursor_x}, {1'b1, 11'd0, 8'h41, 7'd1});
    send(8'h42);
    check("b", {buf_we, buf_addr, buf_wdata, cursor_x}, {1'b1, 11'd1, 8'h42, 7'd2});
    send(8'h0D);
    check("cr2", {buf_we, cursor_x}, {1'b0, 7'd0});
    send(8'h0A);
    check("lf", {buf_we, cursor_x, cursor_y}, {1'b0, 7'd0, 5'd1});
    send(8'h43);
    check("c", {buf_we, buf_addr, buf_wdata, cursor_x, cursor_y}, {1'b1, 11'd80, 8'h43, 7'd1, 5'd1});
    idle();
    tick();
    check("idle_we", {in_ready, buf_we}, {1'b1, 1'b0});

    // Walk down to the bottom row, then scroll once.
    for (int k = 2; k <= 23; k++) begin
      send(8'h0A);
      check("lf_row", {buf_we, cursor_y, first_char}, {1'b0, 5'(k), 11'd0});
    end
    send(8'h0A);
    idle();
    check("scroll1", {in_ready, first_char, cursor_y, cursor_x}, {1'b0, 11'd80, 5'd23, 7'd1});
    for (int j = 0; j < 80; j++) begin
      check("clr_row1", {11'd0, in_ready, buf_we, buf_addr, buf_wdata}, port(1'b0, 1'b1, j, 8'h20));
      tick();
    end
    check("clr_row1_done", {in_ready, buf_we}, {1'b1, 1'b0});

    // Scroll until first_char reaches 1840.
    for (int k = 2; k <= 23; k++) begin
      send(8'h0A);
      idle();
      check("scroll_fc", {21'd0, first_char}, 32'(80 * k));
      writes = 0;
      for (int n = 0; n < 200; n++) begin
        if (in_ready) break;
        writes += int'(buf_we);
        tick();
      end
      check("scroll_ready", {31'd0, in_ready}, 32'd1);
      check("scroll_writes", 32'(writes), 32'd80);
    end

    // Wrap of first_char back to 0; cleared row lands at the end of the buffer.
    send(8'h0A);
    idle();
    check("wrap_fc", {in_ready, first_char, cursor_y}, {1'b0, 11'd0, 5'd23});
    for (int j = 0; j < 80; j++) begin
      check("clr_wrap", {11'd0, in_ready, buf_we, buf_addr, buf_wdata}, port(1'b0, 1'b1, 1840 + j, 8'h20));
      tick();
    end
    check("wrap_done", {in_ready, buf_we}, {1'b1, 1'b0});
    send(8'h58);
    idle();
    check("x_after_wrap", {buf_we, buf_addr, buf_wdata, cursor_x}, {1'b1, 11'd1841, 8'h58, 7'd2});
    tick();

    // Reset in the middle of a row clear.
    send(8'h0A);
    idle();
    for (int j = 1; j < 40; j++) tick();
    check("row_w40", {buf_we, buf_addr, first_char}, {1'b1, 11'd39, 11'd80});
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h51;
    tick();
    check("mid_rst_port", {11'd0, in_ready, buf_we, buf_addr, buf_wdata}, port(1'b0, 1'b0, 0, 8'h20));
    check("mid_rst_home", {cursor_x, cursor_y, first_char}, 32'd0);
    tick();
    check("mid_rst_hold", {in_ready, buf_we, buf_addr}, {1'b0, 1'b0, 11'd0});
    reset = 1'b0;
    idle();
    clear_all_check("reclear");
    send(8'h41);
    idle();
    check("post_rst_a", {buf_we, buf_addr, buf_wdata, cursor_x, cursor_y}, {1'b1, 11'd0, 8'h41, 7'd1, 5'd0});
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
